// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;
  localparam int DATA_BITS   = 8;

endpackage

// File: rtl/uart_tx_fifo_drain_if.sv
// rtl/uart_tx_fifo_drain_if.sv - fifo_8x64 read port as seen by its consumer
interface uart_tx_fifo_drain_if;

  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd_en;

  // master is the reader that issues rd_en, slave is the FIFO
  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd_en
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_rd_en
  );

endinterface

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period counter, bit_done on the last clock of each bit
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_done = (cnt == LAST);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// rtl/uart_tx_fifo_drain.sv - UART transmitter popping bytes from fifo_8x64
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tx_en,
  uart_tx_fifo_drain_if.master        fifo,
  output logic                        tx,
  output logic                        busy,
  output logic [15:0]                 frames_sent
);

  tx_state_t   state, state_nxt;
  logic [7:0]  shreg, shreg_nxt;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic        par_bit, par_nxt;
  logic        tx_nxt, busy_nxt, rd_en_nxt;
  logic [15:0] frames_nxt;
  logic        bit_done, baud_clear, start_ok;

  // The baud counter only runs once a frame is on the line.
  assign baud_clear = (state == ST_IDLE) || (state == ST_FETCH) || (state == ST_LOAD);

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clear    (baud_clear),
    .bit_done (bit_done)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= ST_IDLE;
      tx              <= 1'b1;
      busy            <= 1'b0;
      frames_sent     <= '0;
      fifo.fifo_rd_en <= 1'b0;
      shreg           <= '0;
      bit_cnt         <= '0;
      par_bit         <= 1'b0;
    end else begin
      state           <= state_nxt;
      tx              <= tx_nxt;
      busy            <= busy_nxt;
      frames_sent     <= frames_nxt;
      fifo.fifo_rd_en <= rd_en_nxt;
      shreg           <= shreg_nxt;
      bit_cnt         <= bit_cnt_nxt;
      par_bit         <= par_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    tx_nxt      = tx;
    busy_nxt    = busy;
    rd_en_nxt   = 1'b0;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    par_nxt     = par_bit;
    frames_nxt  = frames_sent;
    start_ok    = tx_en && !fifo.fifo_empty;

    case (state)
      ST_IDLE: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
        if (start_ok) begin
          rd_en_nxt = 1'b1;
          busy_nxt  = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: state_nxt = ST_LOAD;
      ST_LOAD: begin
        shreg_nxt   = fifo.fifo_data;
        par_nxt     = (^fifo.fifo_data) ^ (PARITY == PARITY_ODD);
        bit_cnt_nxt = '0;
        tx_nxt      = 1'b0;
        state_nxt   = ST_START;
      end
      ST_START: begin
        if (bit_done) begin
          tx_nxt    = shreg[0];
          shreg_nxt = {1'b0, shreg[7:1]};
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          if (bit_cnt == 3'(DATA_BITS - 1)) begin
            if (PARITY != PARITY_NONE) begin
              tx_nxt    = par_bit;
              state_nxt = ST_PARITY;
            end else begin
              tx_nxt    = 1'b1;
              state_nxt = ST_STOP;
            end
          end else begin
            tx_nxt      = shreg[0];
            shreg_nxt   = {1'b0, shreg[7:1]};
            bit_cnt_nxt = bit_cnt + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          tx_nxt    = 1'b1;
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          frames_nxt = frames_sent + 16'd1;
          if (start_ok) begin
            rd_en_nxt = 1'b1;
            state_nxt = ST_FETCH;
          end else begin
            busy_nxt  = 1'b0;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb/tb_uart_tx_fifo_drain.sv - randomized bench for uart_tx_fifo_drain, one DUT per parity mode
module tb_uart_tx_fifo_drain;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst;
  logic tx_en;
  always #5 clk = ~clk;

  uart_tx_fifo_drain_if f0 ();
  uart_tx_fifo_drain_if f1 ();
  uart_tx_fifo_drain_if f2 ();

  wire [2:0]  tx_v;
  wire [2:0]  busy_v;
  wire [15:0] fs_v [3];

  uart_tx_fifo_drain #(.CLKS_PER_BIT(CPB), .PARITY(0)) u0 (
    .clk(clk), .rst(rst), .tx_en(tx_en), .fifo(f0),
    .tx(tx_v[0]), .busy(busy_v[0]), .frames_sent(fs_v[0]));
  uart_tx_fifo_drain #(.CLKS_PER_BIT(CPB), .PARITY(1)) u1 (
    .clk(clk), .rst(rst), .tx_en(tx_en), .fifo(f1),
    .tx(tx_v[1]), .busy(busy_v[1]), .frames_sent(fs_v[1]));
  uart_tx_fifo_drain #(.CLKS_PER_BIT(CPB), .PARITY(2)) u2 (
    .clk(clk), .rst(rst), .tx_en(tx_en), .fifo(f2),
    .tx(tx_v[2]), .busy(busy_v[2]), .frames_sent(fs_v[2]));

  // Upstream FIFO models: data_out registered on rd_en, empty from the occupancy
  logic [7:0] fmem [3][64];
  logic [7:0] fdata [3];
  int wr_cnt [3]  = '{default: 0};
  int rd_cnt [3]  = '{default: 0};
  int bad_pop [3] = '{default: 0};
  wire [2:0] rd_v = {f2.fifo_rd_en, f1.fifo_rd_en, f0.fifo_rd_en};

  assign f0.fifo_empty = (wr_cnt[0] == rd_cnt[0]);
  assign f1.fifo_empty = (wr_cnt[1] == rd_cnt[1]);
  assign f2.fifo_empty = (wr_cnt[2] == rd_cnt[2]);
  assign f0.fifo_data  = fdata[0];
  assign f1.fifo_data  = fdata[1];
  assign f2.fifo_data  = fdata[2];

  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (rd_v[g] === 1'b1) begin
        if (wr_cnt[g] == rd_cnt[g]) begin
          bad_pop[g] <= bad_pop[g] + 1;
        end else begin
          fdata[g]  <= fmem[g][rd_cnt[g] % 64];
          rd_cnt[g] <= rd_cnt[g] + 1;
        end
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q [3][$];
  int exp_frames [3] = '{default: 0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int g, input logic [7:0] b);
    fmem[g][wr_cnt[g] % 64] = b;
    wr_cnt[g] = wr_cnt[g] + 1;
    exp_q[g].push_back(b);
  endtask

  // Sample one bit period starting at its first cycle; require a constant level throughout
  task automatic get_bit(input int g, input bit last, output logic v, inout bit stable);
    v = tx_v[g];
    for (int k = 1; k < CPB; k++) begin
      @(negedge clk);
      if (tx_v[g] !== v) stable = 0;
    end
    if (!last) @(negedge clk);
  endtask

  // Decode one frame from instance g and compare with the next expected byte
  task automatic recv(input int g, input int exp_gap);
    int idle = 0;
    bit found = 0;
    bit stable = 1;
    logic s, b, p, st;
    logic [7:0] d, e;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (tx_v[g] === 1'b0) found = 1;
      else idle++;
    end
    check("start_seen", 32'(found), 1);
    if (!found) return;
    if (exp_gap >= 0) check("idle_gap", idle, exp_gap);
    check("frames_before", 32'(fs_v[g]), exp_frames[g]);
    get_bit(g, 0, s, stable);
    check("start_bit", 32'(s), 0);
    for (int i = 0; i < 8; i++) begin
      get_bit(g, 0, b, stable);
      d[i] = b;
    end
    if (g != 0) get_bit(g, 0, p, stable);
    get_bit(g, 1, st, stable);
    check("stop_bit", 32'(st), 1);
    check("bit_width", 32'(stable), 1);
    if (exp_q[g].size() == 0) begin
      check("unexpected_frame", 1, 0);
      return;
    end
    e = exp_q[g].pop_front();
    check("data", 32'(d), 32'(e));
    if (g != 0) check("parity", 32'(p), ($countones(e) + (g == 2 ? 1 : 0)) % 2);
    exp_frames[g] = (exp_frames[g] + 1) % 65536;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int found;
    int bad;
    logic [7:0] lost;

    rst   = 1'b0;
    tx_en = 1'b1;
    push(0, 8'hA5);
    repeat (3) begin
      @(negedge clk);
      check("rst_tx", 32'(tx_v[0]), 1);
      check("rst_rd_en", 32'(f0.fifo_rd_en), 0);
      check("rst_busy", 32'(busy_v[0]), 0);
      check("rst_frames", 32'(fs_v[0]), 0);
    end
    check("rst_no_pop", rd_cnt[0], 0);

    rst = 1'b1;
    recv(0, 2);
    repeat (2) @(negedge clk);
    check("single_frames", 32'(fs_v[0]), exp_frames[0]);
    check("single_empty", 32'(f0.fifo_empty), 1);
    check("single_busy", 32'(busy_v[0]), 0);

    for (int i = 0; i < 64; i++) push(0, 8'($urandom));
    for (int i = 0; i < 64; i++) recv(0, 2);
    repeat (2) @(negedge clk);
    check("burst_frames", 32'(fs_v[0]), exp_frames[0]);
    check("burst_pops", rd_cnt[0], wr_cnt[0]);
    check("burst_busy", 32'(busy_v[0]), 0);

    for (int g = 1; g < 3; g++) begin
      push(g, 8'h07);
      for (int i = 0; i < 3; i++) push(g, 8'($urandom));
      for (int i = 0; i < 4; i++) recv(g, 2);
      repeat (2) @(negedge clk);
      check("parity_frames", 32'(fs_v[g]), exp_frames[g]);
    end

    push(0, 8'($urandom));
    push(0, 8'($urandom));
    fork
      recv(0, 2);
      begin
        repeat (12) @(negedge clk);
        tx_en = 1'b0;
      end
    join
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_v[0] !== 1'b1) bad++;
      if (f0.fifo_rd_en !== 1'b0) bad++;
    end
    check("hold_quiet", bad, 0);
    check("hold_no_pop", rd_cnt[0], wr_cnt[0] - 1);
    check("hold_busy", 32'(busy_v[0]), 0);
    tx_en = 1'b1;
    recv(0, 2);

    push(0, 8'($urandom));
    push(0, 8'($urandom));
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      @(negedge clk);
      if (tx_v[0] === 1'b0) found = 1;
    end
    check("abort_start_seen", found, 1);
    repeat (17) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_tx", 32'(tx_v[0]), 1);
    check("abort_frames", 32'(fs_v[0]), 0);
    @(negedge clk);
    check("abort_busy", 32'(busy_v[0]), 0);
    check("abort_no_pop", rd_cnt[0], wr_cnt[0] - 1);
    lost = exp_q[0].pop_front();
    exp_frames[0] = 0;
    rst = 1'b1;
    recv(0, 2);
    repeat (2) @(negedge clk);
    check("abort_resume_frames", 32'(fs_v[0]), exp_frames[0]);

    check("never_pop_empty", bad_pop[0] + bad_pop[1] + bad_pop[2], 0);
    check("all_sent", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
